spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter DATA_W, default 16, frame width in bits (>= 2).
REQ-002 SHALL have parameter CLK_DIV, default 4, SCLK half-period in clk cycles (>= 1).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port tx_valid  input  1  host requests a frame.
REQ-006 SHALL have port tx_ready  output  1  high only in IDLE; the frame is accepted when tx_valid && tx_ready.
REQ-007 SHALL have port tx_data  input  DATA_W  frame to send, MSB first.
REQ-008 SHALL have port rx_valid  output  1  one-cycle pulse at frame end.
REQ-009 SHALL have port rx_data  output  DATA_W  bits captured from MISO; held until the next rx_valid.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port SCLK  output  1  SPI clock to the accelerator slave.
REQ-012 SHALL have port MOSI  output  1  serial data to the slave.
REQ-013 SHALL have port SS  output  1  slave select, active-low.
REQ-014 SHALL have port MISO  input  1  serial data from the slave.

Function
REQ-015 SHALL operate in SPI mode 0: SCLK idles low, MISO is sampled on SCLK rising, MOSI changes on SCLK falling.
REQ-016 SHALL implement the FSM IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
REQ-017 On accept in IDLE, SHALL latch tx_data into the shift register; in the next cycle SS=0, MOSI=tx_data[DATA_W-1] and the state is SETUP.
REQ-018 SETUP SHALL last CLK_DIV cycles with SCLK=0, then enter XFER.
REQ-019 XFER SHALL toggle SCLK every CLK_DIV cycles, giving DATA_W full periods (2*DATA_W*CLK_DIV cycles).
REQ-020 On each rising edge, SHALL shift MISO into the receive-register LSB.
REQ-021 On each falling edge except the last, SHALL present the next lower bit on MOSI.
REQ-022 After the last falling edge, SHALL enter HOLD: SCLK=0, SS=0 for CLK_DIV cycles.
REQ-023 On entry to GAP, SHALL drive SS=1, update rx_data, and pulse rx_valid for exactly one cycle.
REQ-024 GAP SHALL last CLK_DIV cycles, so SS is high for at least CLK_DIV cycles between frames.
REQ-025 SS SHALL therefore be low for exactly (2*DATA_W+2)*CLK_DIV cycles per frame.
REQ-026 tx_valid outside IDLE SHALL be ignored; tx_data SHALL NOT be sampled except at accept.
REQ-027 A bit counter SHALL count 0..DATA_W-1 and SHALL NOT wrap within a frame.
REQ-028 The divider counter SHALL wrap at CLK_DIV-1.
REQ-029 With tx_valid held high continuously, frames SHALL issue back-to-back with the minimum GAP; tx_ready SHALL be high for exactly one cycle between frames.

Reset
REQ-030 rst SHALL force IDLE, SS=1, SCLK=0, MOSI=0, tx_ready=1 (from the first cycle after reset), busy=0, rx_valid=0, rx_data=0, and clear all counters.
REQ-031 rst mid-frame SHALL abort the frame with no rx_valid; rx_data SHALL become 0.

Configuration
REQ-032 Macro SPI_MASTER_MISO_CAPTURE_EN, when defined, SHALL enable MISO sampling and rx_data as specified.
REQ-033 When SPI_MASTER_MISO_CAPTURE_EN is undefined, rx_data SHALL be constant 0 and MISO unused; rx_valid SHALL still pulse as a frame-done indication.

Structure
REQ-034 Package spi_pkg SHALL hold the FSM state enum (IDLE, SETUP, XFER, HOLD, GAP) and the SPI mode constants CPOL=0, CPHA=0.
REQ-035 Sub-module spi_clk_gen SHALL hold the CLK_DIV counter and emit one-cycle rise_tick/fall_tick strobes plus SCLK; the counter is enabled only in SETUP/XFER/HOLD/GAP.

Verification (DATA_W=16, CLK_DIV=2)
REQ-036 Send tx_data=0xA5C3 -> MOSI sampled at 16 SCLK rises = 1010_0101_1100_0011; SS low for 68 cycles; exactly 16 SCLK rises.
REQ-037 Loopback MISO=MOSI, send 0x3C5A -> rx_valid pulses once, rx_data=0x3C5A.
REQ-038 tx_valid held high, frames 0x0001 then 0xFFFF -> SS high for >= 2 cycles between frames; second frame correct; tx_ready high for 1 cycle between frames.
REQ-039 Assert rst after the 5th SCLK rise -> next cycle SS=1, SCLK=0, tx_ready=1; no rx_valid.
REQ-040 tx_valid pulsed with 0x1234 during XFER of 0x8001 -> 0x1234 is ignored; only one frame observed.
REQ-041 Build without SPI_MASTER_MISO_CAPTURE_EN, MISO=1, send 0x00FF -> rx_valid pulses once, rx_data=0x0000.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and SPI mode constants for the SPI master.
// Optional MISO capture is enabled with SPI_MASTER_MISO_CAPTURE_EN.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_t;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: CLK_DIV-cycle phase counter, SCLK register and edge strobes.
// Counter runs whenever en is high; SCLK toggles only while run is high.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic run,
    output logic tick,
    output logic rise_tick,
    output logic fall_tick,
    output logic sclk
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          sclk_q;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            sclk_q <= CPOL;
        end else if (tick) begin
            sclk_q <= ~sclk_q;
        end
    end

    // leading edge leaves the idle level, trailing edge returns to it
    assign rise_tick = run && tick && (sclk_q == CPOL);
    assign fall_tick = run && tick && (sclk_q != CPOL);
    assign sclk      = sclk_q;

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one DATA_W-bit frame per accepted tx request.
// Define SPI_MASTER_MISO_CAPTURE_EN to capture MISO into rx_data.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              SCLK,
    output logic              MOSI,
    output logic              SS,
    input  logic              MISO
);

    localparam int BW = $clog2(DATA_W);

    state_t            state_q;
    state_t            state_d;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              rx_valid_q;
    logic              tick;
    logic              rise_tick;
    logic              fall_tick;
    logic              sample_tick;
    logic              shift_tick;
    logic              last_bit;

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q != IDLE),
        .run      (state_q == XFER),
        .tick     (tick),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick),
        .sclk     (SCLK)
    );

    assign sample_tick = CPHA ? fall_tick : rise_tick;
    assign shift_tick  = CPHA ? rise_tick : fall_tick;
    assign last_bit    = (bit_cnt == BW'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (tx_valid) state_d = SETUP;
            SETUP:   if (tick) state_d = XFER;
            XFER:    if (shift_tick && last_bit) state_d = HOLD;
            HOLD:    if (tick) state_d = GAP;
            GAP:     if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= (state_q == HOLD) && tick;
            if (state_q == IDLE) begin
                bit_cnt <= '0;
                if (tx_valid) begin
                    shreg <= tx_data;
                end
            end else if (state_q == XFER && shift_tick && !last_bit) begin
                shreg   <= {shreg[DATA_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

`ifdef SPI_MASTER_MISO_CAPTURE_EN
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift  <= '0;
            rx_data_q <= '0;
        end else begin
            if (state_q == XFER && sample_tick) begin
                rx_shift <= {rx_shift[DATA_W-2:0], MISO};
            end
            if (state_q == HOLD && tick) begin
                rx_data_q <= rx_shift;
            end
        end
    end

    assign rx_data = rx_data_q;
`else
    logic unused_ok;
    assign unused_ok = ^{MISO, sample_tick};
    assign rx_data   = '0;
`endif

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign SS       = (state_q == IDLE) || (state_q == GAP);
    assign MOSI     = shreg[DATA_W-1];
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master (DATA_W=16, CLK_DIV=2).
// Expected rx_data follows SPI_MASTER_MISO_CAPTURE_EN when defined.
module tb_spi_master;

    localparam int DW = 16;
    localparam int CD = 2;

    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] rx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_ready;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          busy;
    logic          SCLK;
    logic          MOSI;
    logic          SS;
    logic          MISO;
    logic          loopback = 1'b0;
    logic          miso_val = 1'b0;

    exp_t q[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;
    int   nsent = 0;
    int   nvalid = 0;
    int   rises = 0;
    int   ss_low = 0;
    logic [DW-1:0] mword = '0;
    logic prev_sclk = 1'b0;
    logic prev_ss = 1'b1;
    logic prev_rv = 1'b0;

    assign MISO = loopback ? MOSI : miso_val;

    always #5 clk = ~clk;

    spi_master #(
        .DATA_W (DW),
        .CLK_DIV(CD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data (tx_data),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .busy    (busy),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .SS      (SS),
        .MISO    (MISO)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rxexp(input logic [DW-1:0] v);
`ifdef SPI_MASTER_MISO_CAPTURE_EN
        return v;
`else
        return v & '0;
`endif
    endfunction

    always @(negedge clk) begin
        if (!SS && prev_ss) begin
            rises  = 0;
            ss_low = 1;
            mword  = '0;
        end else if (!SS) begin
            ss_low++;
        end
        if (SCLK && !prev_sclk) begin
            rises++;
            mword = {mword[DW-2:0], MOSI};
        end
        if (rx_valid) begin
            nvalid++;
            check("rxv_width", 32'(prev_rv), 32'(0));
            if (q.size() == 0) begin
                check("spurious_rxv", 32'(1), 32'(0));
            end else begin
                e_mon = q.pop_front();
                check("mosi", 32'(mword), 32'(e_mon.tx));
                check("rises", 32'(rises), 32'(DW));
                check("ss_low", 32'(ss_low), 32'((2 * DW + 2) * CD));
                check("rx_data", 32'(rx_data), 32'(e_mon.rx));
                check("ss_at_rxv", 32'(SS), 32'(1));
            end
        end
        prev_sclk = SCLK;
        prev_ss   = SS;
        prev_rv   = rx_valid;
    end

    task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] rxe);
        int n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) check("send_timeout", 32'(0), 32'(1));
        tx_valid = 1'b1;
        tx_data  = d;
        q.push_back('{tx: d, rx: rxe});
        nsent++;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((q.size() != 0 || !tx_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || !tx_ready) check("done_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int n;
        int hi;
        int rdy;
        logic [DW-1:0] d;

        repeat (3) @(negedge clk);
        check("rst_ss", 32'(SS), 32'(1));
        check("rst_sclk", 32'(SCLK), 32'(0));
        check("rst_mosi", 32'(MOSI), 32'(0));
        check("rst_ready", 32'(tx_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rxv", 32'(rx_valid), 32'(0));
        check("rst_rxd", 32'(rx_data), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        send(16'hA5C3, rxexp(16'h0000));
        check("busy_in_frame", 32'(busy), 32'(1));
        check("ready_in_frame", 32'(tx_ready), 32'(0));
        wait_done();

        loopback = 1'b1;
        send(16'h3C5A, rxexp(16'h3C5A));
        wait_done();
        for (int i = 0; i < 3; i++) begin
            d = DW'($urandom);
            send(d, rxexp(d));
            wait_done();
        end
        loopback = 1'b0;

        miso_val = 1'b1;
        send(16'h00FF, rxexp(16'hFFFF));
        wait_done();
        miso_val = 1'b0;

        // back-to-back frames with tx_valid held high
        tx_valid = 1'b1;
        tx_data  = 16'h0001;
        q.push_back('{tx: 16'h0001, rx: rxexp(16'h0000)});
        nsent++;
        @(negedge clk);
        tx_data = 16'hFFFF;
        q.push_back('{tx: 16'hFFFF, rx: rxexp(16'h0000)});
        nsent++;
        n = 0;
        while (!SS && n < 2000) begin
            @(negedge clk);
            n++;
        end
        hi  = 0;
        rdy = 0;
        n   = 0;
        while (SS && n < 100) begin
            hi++;
            if (tx_ready) rdy++;
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b0;
        check("b2b_ss_high_min", 32'(hi >= CD), 32'(1));
        check("b2b_ss_high", 32'(hi), 32'(CD + 1));
        check("b2b_ready_cycles", 32'(rdy), 32'(1));
        wait_done();

        send(16'h8001, rxexp(16'h0000));
        n = 0;
        while (rises < 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b1;
        tx_data  = 16'h1234;
        repeat (2) @(negedge clk);
        tx_valid = 1'b0;
        wait_done();
        repeat (100) @(negedge clk);

        send(16'hA5A5, rxexp(16'h0000));
        n = 0;
        while (rises != 5 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reached", 32'(rises), 32'(5));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ss", 32'(SS), 32'(1));
        check("abort_sclk", 32'(SCLK), 32'(0));
        check("abort_ready", 32'(tx_ready), 32'(1));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_rxv", 32'(rx_valid), 32'(0));
        check("abort_rxd", 32'(rx_data), 32'(0));
        q.delete();
        nsent--;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);

        send(16'h5AA5, rxexp(16'h0000));
        wait_done();
        repeat (10) @(negedge clk);

        check("frames", 32'(nvalid), 32'(nsent));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
